// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV colour-detection path: field widths, value
// ranges and the frame FSM encoding.
package hsv_pkg;

  localparam int          HSV_W   = 16;
  localparam logic [15:0] HUE_MAX = 16'd255;
  localparam logic [15:0] SV_MAX  = 16'd100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/hsv_window_match.sv
// Combinational HSV window compare. A hue window with lo > hi wraps through
// zero (red band); S and V are plain lower bounds.
module hsv_window_match
  import hsv_pkg::*;
(
  input  logic [HSV_W-1:0] i_h,
  input  logic [HSV_W-1:0] i_s,
  input  logic [HSV_W-1:0] i_v,
  input  logic [HSV_W-1:0] i_h_lo,
  input  logic [HSV_W-1:0] i_h_hi,
  input  logic [HSV_W-1:0] i_s_min,
  input  logic [HSV_W-1:0] i_v_min,
  output logic             o_match
);

  logic w_hue_ok;

  // Hue test, inclusive on both ends in either window form
  always_comb begin
    w_hue_ok = 1'b0;
    if (i_h_lo <= i_h_hi) begin
      w_hue_ok = (i_h >= i_h_lo) && (i_h <= i_h_hi);
    end else begin
      w_hue_ok = (i_h >= i_h_lo) || (i_h <= i_h_hi);
    end
  end

  assign o_match = w_hue_ok && (i_s >= i_s_min) && (i_v >= i_v_min);

endmodule

// File: rtl/hsv_color_detect.sv
// Per-pixel HSV window mask plus per-frame match count and bounding box,
// published once per completed raster frame.
module hsv_color_detect
  import hsv_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int CW     = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [HSV_W-1:0] h,
  input  logic [HSV_W-1:0] s,
  input  logic [HSV_W-1:0] v,
  input  logic [HSV_W-1:0] h_lo,
  input  logic [HSV_W-1:0] h_hi,
  input  logic [HSV_W-1:0] s_min,
  input  logic [HSV_W-1:0] v_min,
  output logic             mask_valid,
  output logic             mask,
  output logic             frame_done,
  output logic             frame_err,
  output logic             found,
  output logic [CW-1:0]    match_count,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [YW-1:0]    y_min,
  output logic [YW-1:0]    y_max
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT-1);

  state_e           r_state;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [HSV_W-1:0] r_h_lo, r_h_hi, r_s_min, r_v_min;
  logic [CW-1:0]    r_cnt;
  logic [XW-1:0]    r_xmn, r_xmx;
  logic [YW-1:0]    r_ymn, r_ymx;
  logic             r_mask_valid, r_mask, r_frame_done, r_frame_err, r_found;
  logic [CW-1:0]    r_count_out;
  logic [XW-1:0]    r_xmn_out, r_xmx_out;
  logic [YW-1:0]    r_ymn_out, r_ymx_out;

  logic             w_sof_take, w_accept, w_err, w_match, w_x_end, w_last;
  logic [HSV_W-1:0] w_h_lo, w_h_hi, w_s_min, w_v_min;
  logic [XW-1:0]    w_px, w_xmn_b, w_xmx_b, w_xmn_n, w_xmx_n;
  logic [YW-1:0]    w_py, w_ymn_b, w_ymx_b, w_ymn_n, w_ymx_n;
  logic [CW-1:0]    w_cnt_b, w_cnt_n;

  // An SOF pixel restarts the frame from any state and uses the live thresholds
  assign w_sof_take = in_valid && in_sof;
  assign w_accept   = in_valid && (in_sof || (r_state == ST_ACTIVE));
  assign w_err      = w_sof_take && (r_state == ST_ACTIVE) && ((r_x != '0) || (r_y != '0));
  assign w_h_lo     = w_sof_take ? h_lo  : r_h_lo;
  assign w_h_hi     = w_sof_take ? h_hi  : r_h_hi;
  assign w_s_min    = w_sof_take ? s_min : r_s_min;
  assign w_v_min    = w_sof_take ? v_min : r_v_min;
  assign w_px       = w_sof_take ? '0 : r_x;
  assign w_py       = w_sof_take ? '0 : r_y;
  assign w_x_end    = (w_px == X_LAST);
  assign w_last     = w_x_end && (w_py == Y_LAST);
  assign w_cnt_b    = w_sof_take ? '0 : r_cnt;
  assign w_xmn_b    = w_sof_take ? '1 : r_xmn;
  assign w_xmx_b    = w_sof_take ? '0 : r_xmx;
  assign w_ymn_b    = w_sof_take ? '1 : r_ymn;
  assign w_ymx_b    = w_sof_take ? '0 : r_ymx;

  hsv_window_match u_match (
    .i_h     (h),
    .i_s     (s),
    .i_v     (v),
    .i_h_lo  (w_h_lo),
    .i_h_hi  (w_h_hi),
    .i_s_min (w_s_min),
    .i_v_min (w_v_min),
    .o_match (w_match)
  );

  // Working accumulator update for the current pixel
  always_comb begin
    w_cnt_n = w_cnt_b;
    w_xmn_n = w_xmn_b;
    w_xmx_n = w_xmx_b;
    w_ymn_n = w_ymn_b;
    w_ymx_n = w_ymx_b;
    if (w_accept && w_match) begin
      w_cnt_n = (w_cnt_b == '1) ? w_cnt_b : (w_cnt_b + CW'(1));
      w_xmn_n = (w_px < w_xmn_b) ? w_px : w_xmn_b;
      w_xmx_n = (w_px > w_xmx_b) ? w_px : w_xmx_b;
      w_ymn_n = (w_py < w_ymn_b) ? w_py : w_ymn_b;
      w_ymx_n = (w_py > w_ymx_b) ? w_py : w_ymx_b;
    end else begin
      w_cnt_n = w_cnt_b;
    end
  end

  // Frame FSM, raster position and threshold shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_h_lo  <= '0;
      r_h_hi  <= '0;
      r_s_min <= '0;
      r_v_min <= '0;
    end else begin
      if (w_sof_take) begin
        r_h_lo  <= h_lo;
        r_h_hi  <= h_hi;
        r_s_min <= s_min;
        r_v_min <= v_min;
      end
      if (w_accept) begin
        r_x     <= w_x_end ? '0 : (w_px + XW'(1));
        r_y     <= w_last ? '0 : (w_x_end ? (w_py + YW'(1)) : w_py);
        r_state <= w_last ? ST_DONE : ST_ACTIVE;
      end else if (r_state == ST_DONE) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Working accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_xmn <= '1;
      r_xmx <= '0;
      r_ymn <= '1;
      r_ymx <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_n;
      r_xmn <= w_xmn_n;
      r_xmx <= w_xmx_n;
      r_ymn <= w_ymn_n;
      r_ymx <= w_ymx_n;
    end
  end

  // Per-pixel mask, pulses and published frame results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask_valid <= 1'b0;
      r_mask       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_found      <= 1'b0;
      r_count_out  <= '0;
      r_xmn_out    <= '1;
      r_xmx_out    <= '0;
      r_ymn_out    <= '1;
      r_ymx_out    <= '0;
    end else begin
      r_mask_valid <= w_accept;
      r_mask       <= w_accept && w_match;
      r_frame_done <= w_accept && w_last;
      r_frame_err  <= w_err;
      if (w_accept && w_last) begin
        r_found     <= (w_cnt_n != '0);
        r_count_out <= w_cnt_n;
        r_xmn_out   <= (w_cnt_n != '0) ? w_xmn_n : '1;
        r_xmx_out   <= (w_cnt_n != '0) ? w_xmx_n : '0;
        r_ymn_out   <= (w_cnt_n != '0) ? w_ymn_n : '1;
        r_ymx_out   <= (w_cnt_n != '0) ? w_ymx_n : '0;
      end
    end
  end

  assign mask_valid  = r_mask_valid;
  assign mask        = r_mask;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;
  assign found       = r_found;
  assign match_count = r_count_out;
  assign x_min       = r_xmn_out;
  assign x_max       = r_xmx_out;
  assign y_min       = r_ymn_out;
  assign y_max       = r_ymx_out;

endmodule

// File: doc/hsv_color_detect.md
# hsv_color_detect

Streaming colour-detection stage directly downstream of the RGB-to-HSV converter. Consumes one H/S/V pixel per valid cycle in raster order, marks pixels inside a programmable HSV window, and accumulates per-frame match count and bounding box. Results are published once per frame for the tracking/control logic; the per-pixel mask feeds the overlay path.

## Interface
Parameters:
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, lines per frame
- `XW`, `$clog2(WIDTH)`, x coordinate width
- `YW`, `$clog2(HEIGHT)`, y coordinate width
- `CW`, `$clog2(WIDTH*HEIGHT+1)`, match counter width

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1: pixel clock
- `rst` in 1: synchronous active-high reset
- `in_valid` in 1: h/s/v carry a pixel this cycle
- `in_sof` in 1: qualified by `in_valid`; this pixel is (0,0) of a new frame
- `h`, `s`, `v` in 16 each: hue 0..255 scale, saturation/value 0..100
- `h_lo`, `h_hi`, `s_min`, `v_min` in 16 each: detection window
- `mask_valid` out 1: registered copy of `in_valid` for accepted pixels
- `mask` out 1: pixel matched
- `frame_done` out 1: one-cycle pulse, results updated
- `frame_err` out 1: one-cycle pulse, frame aborted by early `in_sof`
- `found` out 1: ≥1 match in last completed frame
- `match_count` out CW: matches in last completed frame
- `x_min`, `x_max` out XW; `y_min`, `y_max` out YW: bounding box of last completed frame

## Operation
- Thresholds sampled into shadow registers on the `in_sof` pixel; constant for the rest of the frame.
- Match: `s >= s_min && v >= v_min && hue_ok`. If `h_lo <= h_hi`: `hue_ok = h_lo <= h <= h_hi`; else (red wrap) `hue_ok = h >= h_lo || h <= h_hi`. Comparisons unsigned 16-bit. SOF pixel uses the newly sampled thresholds.
- FSM: IDLE → ACTIVE on `in_valid && in_sof`. ACTIVE: each valid pixel advances x; x == WIDTH-1 wraps to 0 and increments y. Valid pixel at (WIDTH-1, HEIGHT-1) → DONE. DONE → IDLE unconditionally next cycle (frame_done cycle); `in_valid && in_sof` in that cycle starts a new frame (→ ACTIVE).
- IDLE: valid pixels without `in_sof` ignored (no mask_valid).
- `in_sof` while ACTIVE and not at pixel (0,0): `frame_err` pulses, accumulators cleared, pixel taken as (0,0) of new frame; no `frame_done` for aborted frame.
- Accumulators (working): count, bbox min/max. On SOF cleared to count 0, x_min/y_min all-ones, x_max/y_max 0, then updated by the SOF pixel's match.
- On frame completion working values copied to outputs; `found = count != 0`. When not found, published bbox is x_min/y_min = all-ones, max = 0.
- Count saturates at all-ones (cannot overflow with default CW; enforced anyway).

## Timing
- `mask`/`mask_valid`: 1-cycle latency from input pixel.
- `frame_done`: asserted the cycle after the last pixel is sampled; result outputs change in that same cycle and hold until next `frame_done` or reset.
- `frame_err`: cycle after the offending `in_sof` pixel.
- `in_valid` may drop anywhere; counters hold.
- Reset: state IDLE; all outputs 0 except `x_min`/`y_min` all-ones; shadow thresholds 0. Reset mid-frame discards the frame, no pulses.

## Structure
- Shared package `hsv_pkg`: HSV field width (16), hue scale max (255), S/V max (100), FSM state enum (IDLE, ACTIVE, DONE).
- One sub-module `hsv_window_match`: combinational window compare incl. hue wrap; reused by overlay logic.
- Top holds FSM, x/y counters, accumulators, result registers.

## Test plan
- WIDTH=4, HEIGHT=2, window h 80..100, s_min 50, v_min 50; pixels (1,0) and (2,1) = h 90/s 60/v 60, rest h 0 → mask 1 on those two only; frame_done count 2, bbox x 1..2, y 0..1, found 1.
- Hue wrap: h_lo 240, h_hi 10; pixels h 250, 5, 11, 239 at s/v 100 → masks 1,1,0,0.
- No matches in frame → frame_done, count 0, found 0, x_min all-ones, x_max 0.
- Early `in_sof` at pixel index 5 of 8 → frame_err pulse, no frame_done; following full frame reports only its own matches.
- `in_valid` gaps of random length between pixels and back-to-back frames (SOF in frame_done cycle) → identical results to gap-free run; one frame_done per frame.
- Thresholds changed mid-frame → no effect until next SOF; `rst` mid-frame → outputs return to reset values, no pulses.
